// File: rtl/shreg_arb_pkg.sv
// Shared types and helpers for the shreg_arb round-robin register arbiter.
package shreg_arb_pkg;

   typedef enum logic {ARB_IDLE = 1'b0, ARB_FULL = 1'b1} arbstate_t;

   // Index width for n requesters; never narrower than one bit.
   function automatic int idx_w(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/shreg_arb_rr_pick.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            any
);

   logic [IW:0] cand_s;

   always_comb begin
      gnt    = '0;
      idx    = '0;
      any    = 1'b0;
      cand_s = '0;
      for (int k = 0; k < NREQ; k++) begin
         // ptr is always below NREQ, so one subtraction is enough to wrap
         cand_s = {1'b0, ptr} + (IW+1)'(k);
         if (cand_s >= (IW+1)'(NREQ)) begin
            cand_s = cand_s - (IW+1)'(NREQ);
         end else begin
            cand_s = cand_s;
         end
         if (!any && req[cand_s]) begin
            any         = 1'b1;
            idx         = cand_s[IW-1:0];
            gnt[cand_s] = 1'b1;
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/shreg_arb.sv
// Round-robin arbiter sharing one registered data slot between NREQ producers
// and a single consumer with a valid/ack handshake.
module shreg_arb
   import shreg_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NREQ-1:0]             Req,
   input  logic [NREQ-1:0][WIDTH-1:0]  Data,
   output logic [NREQ-1:0]             Gnt,
   input  logic                        Ack,
   input  logic                        Flush,
   output logic [WIDTH-1:0]            Q,
   output logic                        QValid,
   output logic [idx_w(NREQ)-1:0]      QOwner
);

   localparam int IW = idx_w(NREQ);

   arbstate_t         state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [WIDTH-1:0]  q_q, q_d;

   logic [NREQ-1:0]   pick_gnt_s;
   logic [IW-1:0]     win_s;
   logic              any_s;
   logic              load_ok_s;
   logic              en_s;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req (Req),
      .ptr (ptr_q),
      .gnt (pick_gnt_s),
      .idx (win_s),
      .any (any_s)
   );

   assign load_ok_s = ((state_q == ARB_IDLE) || Ack) && !Flush;
   assign en_s      = load_ok_s && any_s;

   // Grant is gated by reset so nothing is offered while the block is held in reset.
   always_comb begin
      if (reset && load_ok_s) begin
         Gnt = pick_gnt_s;
      end else begin
         Gnt = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      q_d     = q_q;
      if (Flush) begin
         state_d = ARB_IDLE;
      end else if (en_s) begin
         state_d = ARB_FULL;
         owner_d = win_s;
         q_d     = Data[win_s];
         ptr_d   = (win_s == IW'(NREQ-1)) ? '0 : win_s + IW'(1);
      end else if (load_ok_s) begin
         state_d = ARB_IDLE;
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         q_q     <= q_d;
      end
   end

   assign Q      = q_q;
   assign QValid = (state_q == ARB_FULL);
   assign QOwner = owner_q;

endmodule

// File: tb/tb_shreg_arb.sv
// Randomized scoreboard bench for shreg_arb (NREQ=4) plus a wrap check at NREQ=3.
module tb_shreg_arb;

   localparam int N = 4;
   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset;
   logic [N-1:0]         req, gnt;
   logic [N-1:0][W-1:0]  data;
   logic                 ack, flush;
   logic [W-1:0]         q;
   logic                 qv;
   logic [1:0]           qo;

   logic                 reset3;
   logic [2:0]           req3, gnt3;
   logic [2:0][7:0]      data3;
   logic                 ack3, flush3;
   logic [7:0]           q3;
   logic                 qv3;
   logic [1:0]           qo3;

   shreg_arb #(.NREQ(N), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .Req(req), .Data(data), .Gnt(gnt),
      .Ack(ack), .Flush(flush), .Q(q), .QValid(qv), .QOwner(qo)
   );

   shreg_arb #(.NREQ(3), .WIDTH(8)) dut3 (
      .clk(clk), .reset(reset3), .Req(req3), .Data(data3), .Gnt(gnt3),
      .Ack(ack3), .Flush(flush3), .Q(q3), .QValid(qv3), .QOwner(qo3)
   );

   typedef struct {
      logic [N-1:0] gnt;
      logic         v;
      logic [W-1:0] q;
      logic [1:0]   own;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // reference model of the shared slot
   bit           m_v   = 1'b0;
   logic [W-1:0] m_q   = '0;
   int           m_own = 0;
   int           m_ptr = 0;

   bit   mon_en    = 1'b0;
   bit   have_prev = 1'b0;
   bit   done3     = 1'b0;
   exp_t prev;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_v = 1'b0; m_q = '0; m_own = 0; m_ptr = 0;
   endtask

   // One cycle of stimulus; the model's expectation goes to the scoreboard.
   task automatic cyc(input logic [N-1:0] r, input logic a, input logic f,
                      input logic [N-1:0][W-1:0] d, output logic [N-1:0] g);
      exp_t e;
      bit   lok;
      int   win;
      @(posedge clk);
      #1;
      req = r; ack = a; flush = f; data = d;
      lok = (!m_v || a) && !f;
      win = -1;
      if (lok) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (win < 0 && r[idx]) win = idx;
         end
      end
      g = '0;
      if (win >= 0) g[win] = 1'b1;
      if (f) begin
         m_v = 1'b0;
      end else if (win >= 0) begin
         m_v = 1'b1; m_q = d[win]; m_own = win; m_ptr = (win + 1) % N;
      end else if (lok) begin
         m_v = 1'b0;
      end
      e.gnt = g; e.v = m_v; e.q = m_q; e.own = 2'(m_own);
      sb.push_back(e);
      mon_en = 1'b1;
   endtask

   function automatic logic [N-1:0][W-1:0] rnd_data();
      logic [N-1:0][W-1:0] d;
      for (int i = 0; i < N; i++) d[i] = $urandom;
      return d;
   endfunction

   // Monitor: grant checked in its own cycle, registered outputs one cycle later.
   initial begin
      forever begin
         exp_t e;
         @(negedge clk);
         if (mon_en) begin
            if (have_prev) begin
               chk("qvalid", 64'(qv), 64'(prev.v));
               if (prev.v) begin
                  chk("q", 64'(q), 64'(prev.q));
                  chk("qowner", 64'(qo), 64'(prev.own));
               end
            end
            if (sb.size() == 0) begin
               tests++; fails++;
               $display("FAIL scoreboard_empty: got no expectation, required one at %0t", $time);
               have_prev = 1'b0;
            end else begin
               e = sb.pop_front();
               chk("gnt", 64'(gnt), 64'(e.gnt));
               prev = e;
               have_prev = 1'b1;
            end
         end
      end
   end

   // NREQ=3: all requesting with Ack held high must grant 0,1,2,0,1,2,0.
   initial begin
      logic [2:0] eg;
      reset3 = 1'b0; req3 = '0; ack3 = 1'b1; flush3 = 1'b0;
      data3  = {8'h33, 8'h22, 8'h11};
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset3 = 1'b1;
      @(posedge clk);
      #1;
      req3 = 3'b111;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         eg = 3'b001 << (k % 3);
         chk("dut3_gnt", 64'(gnt3), 64'(eg));
         if (k > 0) begin
            chk("dut3_qvalid", 64'(qv3), 64'd1);
            chk("dut3_qowner", 64'(qo3), 64'((k - 1) % 3));
            chk("dut3_q", 64'(q3), 64'(8'h11 * ((k - 1) % 3 + 1)));
         end
      end
      done3 = 1'b1;
   end

   initial begin
      logic [N-1:0][W-1:0] d;
      logic [N-1:0]        g;
      logic [N-1:0]        pend;
      logic [31:0]         r;
      logic                a, f;

      reset = 1'b0; req = 4'b1111; ack = 1'b1; flush = 1'b0; data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_qvalid", 64'(qv), 64'd0);
      chk("rst_q", 64'(q), 64'd0);
      chk("rst_qowner", 64'(qo), 64'd0);
      req = '0;
      @(negedge clk);
      reset = 1'b1;
      model_reset();

      // rotation from Ptr=0
      for (int i = 0; i < 5; i++) cyc(4'b1111, 1'b1, 1'b0, rnd_data(), g);
      cyc(4'b0000, 1'b1, 1'b0, rnd_data(), g);

      // single request, then stall and release
      d = rnd_data(); d[2] = 32'h0000_00A5;
      cyc(4'b0100, 1'b0, 1'b0, d, g);
      d = rnd_data(); d[0] = 32'h0000_0011;
      cyc(4'b0001, 1'b1, 1'b0, d, g);
      repeat (3) cyc(4'b0001, 1'b0, 1'b0, rnd_data(), g);
      d = rnd_data(); d[0] = 32'h0000_0022;
      cyc(4'b0001, 1'b1, 1'b0, d, g);

      // flush overrides Ack and Req
      cyc(4'b0010, 1'b1, 1'b1, rnd_data(), g);
      cyc(4'b0010, 1'b1, 1'b0, rnd_data(), g);
      cyc(4'b0000, 1'b0, 1'b1, rnd_data(), g);

      // randomized traffic; a request stays up until granted
      pend = '0;
      repeat (500) begin
         r = $urandom;
         pend = pend | (r[3:0] & r[7:4]);
         a = ($urandom_range(0, 9) < 7);
         f = ($urandom_range(0, 19) == 0);
         cyc(pend, a, f, rnd_data(), g);
         pend = pend & ~g;
      end

      // reset in the middle of operation with QOwner=3
      cyc(4'b0000, 1'b1, 1'b0, rnd_data(), g);
      cyc(4'b1000, 1'b1, 1'b0, rnd_data(), g);
      cyc(4'b0000, 1'b0, 1'b0, rnd_data(), g);
      @(negedge clk);
      #1;
      mon_en = 1'b0; have_prev = 1'b0;
      chk("pre_rst_qvalid", 64'(qv), 64'd1);
      chk("pre_rst_qowner", 64'(qo), 64'd3);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_qvalid", 64'(qv), 64'd0);
      chk("mid_rst_q", 64'(q), 64'd0);
      chk("mid_rst_qowner", 64'(qo), 64'd0);
      chk("mid_rst_gnt", 64'(gnt), 64'd0);
      req = '0;
      model_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) cyc(4'b1111, 1'b1, 1'b0, rnd_data(), g);
      repeat (3) cyc(4'b0000, 1'b1, 1'b0, rnd_data(), g);

      @(negedge clk);
      #1;
      mon_en = 1'b0;
      chk("sb_drained", 64'(sb.size()), 64'd0);
      chk("dut3_done", 64'(done3), 64'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shreg_arb.md
# shreg_arb

Round-robin arbiter and sequencer that shares one enabled data register between NREQ requesters and a single consumer. It decides which requester loads the register and when the register may be reloaded, and it tracks occupancy with a valid/ack handshake. It sits between multiple producer units, such as execution-unit result buses, and one shared pipeline/holding register. The block provides one-transfer-per-cycle throughput when the consumer keeps up.

## Interface
- NREQ, default 4: number of requesters; at least 2; not required to be a power of 2.
- WIDTH, default 32: data width of the shared register.
- clk  in  1: clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-low (0 = reset).
- Req  in  NREQ: per-requester request; Req[i] stays high until Gnt[i] is seen.
- Data  in  NREQ x WIDTH: per-requester payload; sampled only when granted.
- Gnt  out  NREQ: combinational one-hot grant, or all zero; Req[i] & Gnt[i] is a transfer.
- Ack  in  1: consumer accepts Q this cycle; ignored when QValid=0.
- Flush  in  1: synchronous discard of held data; no grant is issued this cycle.
- Q  out  WIDTH: registered shared-register contents.
- QValid  out  1: Q holds unconsumed data.
- QOwner  out  $clog2(NREQ): index of the requester that loaded Q.

## Operation
- Two states, IDLE (register empty) and FULL (QValid=1). QValid is the state decode.
- Reset values: state=IDLE, QValid=0, Q=0, QOwner=0, Ptr=0. Gnt=0 while reset is asserted.
- Ptr is the round-robin start index. The winner is the first i with Req[i]=1, searching Ptr, Ptr+1, … and wrapping from NREQ-1 to 0.
- Load is allowed when (IDLE | (FULL & Ack)) & ~Flush.
  - If load is allowed and any Req is high: Gnt = onehot(winner); register enable=1; Q <= Data[winner]; QOwner <= winner; Ptr <= winner+1 (NREQ-1 wraps to 0); next state=FULL.
  - If load is allowed and no Req is high: Gnt=0. FULL & Ack goes to IDLE. IDLE stays IDLE.
- FULL & ~Ack & ~Flush: Gnt=0, register enable=0, Q/QOwner/Ptr hold.
- Flush, in any state: Gnt=0; next state=IDLE; Q, QOwner and Ptr hold. Flush overrides Ack and Req in the same cycle.
- Fairness: a continuously held Req[i] is granted within NREQ transfers.
- Ptr advances only on a transfer. It never advances on idle cycles, stalls or flushes.
- Data is not forwarded combinationally to Q. Q changes only at a clock edge with enable=1.

## Timing
- Grant latency: Gnt is asserted in the same cycle as Req when load is allowed (combinational from Req, Ptr, state, Ack, Flush).
- Load latency: Q and QValid update on the edge ending the grant cycle, so data is visible 1 cycle after the grant.
- Throughput: 1 transfer per cycle when Ack=1 every FULL cycle (back-to-back grants while FULL).
- Reset assertion forces all outputs to their reset values immediately, without waiting for clk, including mid-transfer. Deassertion takes effect at the next clk edge.
- Simultaneous Ack and Req in FULL: the consume and the new load both occur on the same edge, and QValid stays 1.
- Ack while IDLE has no effect.

## Structure
- Package shreg_arb_pkg contains:
  - typedef enum logic {ARB_IDLE, ARB_FULL} arbstate_t;
  - helper function for index width ($clog2 of NREQ, minimum 1).
- Sub-module rr_pick (combinational): inputs Req and Ptr; outputs one-hot Gnt, binary winner index and an any-request flag.
- Top level holds:
  - state flop, Ptr flop and QOwner flop (all asynchronous reset);
  - WIDTH-bit data register with enable = load allowed & any request;
  - Data mux selected by the winner index.

## Test plan
- Reset: hold reset=0 with Req=1111, Ack=1 -> Gnt=0000, QValid=0, Q=0, QOwner=0. Release reset -> first grant goes to requester 0.
- Single request: IDLE, Req=0100, Data[2]=0xA5 -> Gnt=0100 in the same cycle. Next cycle: QValid=1, Q=0xA5, QOwner=2, Ptr=3.
- Rotation: Req=1111 held, Ack=1 every cycle, NREQ=4 -> grants 0,1,2,3,0 on consecutive cycles, one transfer per cycle. Also run NREQ=3: wrap 2->0.
- Stall: FULL with Q=0x11, Req=0001, Ack=0 for 3 cycles -> Gnt=0, Q=0x11 steady. Ack=1 -> Gnt=0001 that cycle, new Q next cycle, QValid stays 1.
- Flush: FULL, Flush=1 with Ack=1 and Req=0010 -> Gnt=0. Next cycle QValid=0 and Ptr unchanged. The following cycle grants requester 1.
- Reset mid-operation: FULL with QOwner=3; drive reset=0 between clock edges -> QValid=0, Q=0 and QOwner=0 immediately. After release, Ptr=0 ordering restarts.
